// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// ALU operation classes, mux select codes and the bundled control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    IMM_EX   = 4'd9,
    IMM_WB   = 4'd10,
    JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath control in one word so a state can start from all-zero.
  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_ADDI, OP_ANDI, OP_ORI: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state function of the multicycle sequencer. mem_ready is
// tied high by the parent when memory wait states are not built in.
module multicycle_next_state
  import multicycle_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output state_e      next_state
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives next_state and no latch is inferred.
    next_state = FETCH;
    case (state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:              next_state = MEMADR;
          OP_RTYPE:                  next_state = RTYPE_EX;
          OP_BEQ, OP_BNE:            next_state = BRANCH;
          OP_J:                      next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  next_state = IMM_EX;
          default:                   next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:    next_state = FETCH;
      MEMWR:    next_state = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: next_state = RTYPE_WB;
      RTYPE_WB: next_state = FETCH;
      BRANCH:   next_state = FETCH;
      IMM_EX:   next_state = IMM_WB;
      IMM_WB:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control sequencer for the multicycle MIPS datapath.
// Optional memory wait states are built when MULTICYCLE_MEM_WAIT_EN is defined.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);

  state_e state_q;
  state_e state_d;
  logic   ready;
  ctrl_t  ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  multicycle_next_state u_next_state (
    .state      (state_q),
    .op         (op),
    .mem_ready  (ready),
    .next_state (state_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = ready;
        ctrl.pc_en     = ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !op_supported(op);
        ctrl.instr_done = !op_supported(op);
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = ready;
      end
      RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pc_en      = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
      end
      IMM_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Reset suppresses every strobe, including any write in a half-finished instruction.
    if (reset) ctrl = '0;
  end

  assign pc_en      = ctrl.pc_en;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ALUOP_W'(ctrl.alu_op);
  assign pc_src     = ctrl.pc_src;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state_out  = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle output words are
// queued as stimulus is driven and compared at the following falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_out;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .op         (op),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state_out  (state_out)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } obs_t;

  obs_t tab [12];
  obs_t sb [$];
  int   total = 0;
  int   bad   = 0;

  // flags order: pc_en i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write instr_done illegal_op
  function automatic obs_t mk(input logic [3:0] st, input logic [9:0] flags,
                              input logic a, input logic [1:0] b,
                              input logic [2:0] aop, input logic [1:0] pcs);
    mk = {st, flags, a, b, aop, pcs};
  endfunction

  task automatic step(input obs_t e, input string tag);
    obs_t got;
    obs_t want;
    sb.push_back(e);
    @(negedge clk);
    got = {state_out, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, instr_done, illegal_op, alu_src_a, alu_src_b,
           alu_op, pc_src};
    want = sb.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t e;
    tab[0]  = mk(4'd0,  10'b1010100000, 1'b0, 2'b01, 3'b000, 2'b00);
    tab[1]  = mk(4'd1,  10'b0000000000, 1'b0, 2'b11, 3'b000, 2'b00);
    tab[2]  = mk(4'd2,  10'b0000000000, 1'b1, 2'b10, 3'b000, 2'b00);
    tab[3]  = mk(4'd3,  10'b0110000000, 1'b0, 2'b00, 3'b000, 2'b00);
    tab[4]  = mk(4'd4,  10'b0000001110, 1'b0, 2'b00, 3'b000, 2'b00);
    tab[5]  = mk(4'd5,  10'b0101000010, 1'b0, 2'b00, 3'b000, 2'b00);
    tab[6]  = mk(4'd6,  10'b0000000000, 1'b1, 2'b00, 3'b010, 2'b00);
    tab[7]  = mk(4'd7,  10'b0000010110, 1'b0, 2'b00, 3'b000, 2'b00);
    tab[8]  = mk(4'd8,  10'b0000000010, 1'b1, 2'b00, 3'b001, 2'b01);
    tab[9]  = mk(4'd9,  10'b0000000000, 1'b1, 2'b10, 3'b000, 2'b00);
    tab[10] = mk(4'd10, 10'b0000000110, 1'b0, 2'b00, 3'b000, 2'b00);
    tab[11] = mk(4'd11, 10'b1000000010, 1'b0, 2'b00, 3'b000, 2'b10);

    reset = 1'b1;
    op    = 6'h00;
    zero  = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    step('0, "reset_outputs");

    // R-type
    reset = 1'b0;
    op    = 6'h00;
    step(tab[0], "rtype_fetch");
    step(tab[1], "rtype_decode");
    step(tab[6], "rtype_ex");
    step(tab[7], "rtype_wb");

    // lw
    op = 6'h23;
    step(tab[0], "lw_fetch");
    step(tab[1], "lw_decode");
    step(tab[2], "lw_memadr");
    step(tab[3], "lw_memrd");
    step(tab[4], "lw_memwb");

    // beq taken, bne not taken, bne taken
    op = 6'h04; zero = 1'b1;
    step(tab[0], "beq_fetch");
    step(tab[1], "beq_decode");
    e = tab[8]; e.pc_en = 1'b1;
    step(e, "beq_taken");
    op = 6'h05; zero = 1'b1;
    step(tab[0], "bne_fetch");
    step(tab[1], "bne_decode");
    step(tab[8], "bne_not_taken");
    op = 6'h05; zero = 1'b0;
    step(tab[0], "bne2_fetch");
    step(tab[1], "bne2_decode");
    e = tab[8]; e.pc_en = 1'b1;
    step(e, "bne_taken");

    // j
    op = 6'h02;
    step(tab[0], "j_fetch");
    step(tab[1], "j_decode");
    step(tab[11], "j_jump");

    // immediate ops
    op = 6'h08;
    step(tab[0], "addi_fetch");
    step(tab[1], "addi_decode");
    step(tab[9], "addi_ex");
    step(tab[10], "addi_wb");
    op = 6'h0C;
    step(tab[0], "andi_fetch");
    step(tab[1], "andi_decode");
    e = tab[9]; e.alu_op = 3'b011;
    step(e, "andi_ex");
    step(tab[10], "andi_wb");
    op = 6'h0D;
    step(tab[0], "ori_fetch");
    step(tab[1], "ori_decode");
    e = tab[9]; e.alu_op = 3'b100;
    step(e, "ori_ex");
    step(tab[10], "ori_wb");

    // sw
    op = 6'h2B;
    step(tab[0], "sw_fetch");
    step(tab[1], "sw_decode");
    step(tab[2], "sw_memadr");
    step(tab[5], "sw_memwr");

    // illegal opcode
    op = 6'h3F;
    step(tab[0], "ill_fetch");
    e = tab[1]; e.illegal_op = 1'b1; e.instr_done = 1'b1;
    step(e, "ill_decode");
    step(tab[0], "ill_back_to_fetch");

    // reset raised while in MEMWR
    op = 6'h2B;
    step(tab[1], "swr_decode");
    step(tab[2], "swr_memadr");
    reset = 1'b1;
    step('0, "rst_in_memwr");
    reset = 1'b0;
    step(tab[0], "fetch_after_rst");
    step(tab[1], "sw2_decode");
    step(tab[2], "sw2_memadr");

`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b0;
    e = tab[5]; e.instr_done = 1'b0;
    for (int i = 0; i < 3; i++) step(e, "memwr_wait");
    mem_ready = 1'b1;
    step(tab[5], "memwr_ready");
    mem_ready = 1'b0;
    e = tab[0]; e.pc_en = 1'b0; e.ir_write = 1'b0;
    step(e, "fetch_wait");
    mem_ready = 1'b1;
    step(tab[0], "fetch_ready");
    step(tab[1], "decode_after_wait");
`else
    step(tab[5], "sw2_memwr");
    step(tab[0], "sw2_next_fetch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
